ysyx_23060201_lsu_load: RTL
===========================

YSYX_23060201_LSU_LOAD -- requirements
Module: ysyx_23060201_lsu_load

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high.
REQ-002 SHALL provide parameter: MEM_ADDR_WIDTH, 32, load address width.
REQ-003 SHALL provide ports, one per line:
  clk  input  1  system clock, rising edge
  rst  input  1  asynchronous reset, active-high
  ld_valid  input  1  EXU load request valid
  ld_ready  output  1  unit can accept a load
  ld_addr  input  MEM_ADDR_WIDTH  byte address of load
  ld_func3  input  3  RV32I load type
  ld_rd  input  5  destination register index
  mem_ren  output  1  memory read request valid
  mem_raddr  output  MEM_ADDR_WIDTH  word-aligned read address
  mem_rready  input  1  memory accepts read request
  mem_rvalid  input  1  read data valid
  mem_rdata  input  32  read data word
  gpr_wen  output  1  GPR write-back enable
  gpr_waddr  output  5  GPR write address
  gpr_wdata  output  32  extracted, extended load result
  ld_err  output  1  misaligned-load pulse

Function
REQ-004 SHALL implement FSM IDLE -> REQ -> WAIT -> WB -> IDLE.
REQ-005 SHALL drive ld_ready=1 only in IDLE; handshake completes on ld_valid & ld_ready.
REQ-006 SHALL register ld_addr, ld_func3, ld_rd on handshake and ignore ld_* inputs otherwise.
REQ-007 SHALL in REQ drive mem_ren=1 and mem_raddr={addr[MSB:2],2'b00}, holding both stable until mem_rready=1, then enter WAIT.
REQ-008 SHALL sample mem_rvalid/mem_rdata only in WAIT; mem_rvalid in IDLE, REQ, or WB is ignored.
REQ-009 SHALL in WAIT on mem_rvalid=1 register the extracted result and enter WB.
REQ-010 SHALL extract: 000 LB sign-extend byte addr[1:0]; 001 LH sign-extend half addr[1]; 010 LW full word; 100 LBU zero-extend byte; 101 LHU zero-extend half; 011/110/111 treated as LW.
REQ-011 SHALL in WB assert gpr_wen for exactly one cycle with gpr_waddr=rd and gpr_wdata=result, unless rd=0, in which case gpr_wen=0.
REQ-012 SHALL hold gpr_wdata and gpr_waddr stable from WB until the next WB; gpr_wen=0 outside WB.
REQ-013 SHALL achieve minimum latency of 3 cycles from handshake edge to gpr_wen high, with mem_rready=1 in REQ and mem_rvalid=1 on the first WAIT cycle.
REQ-014 SHALL tolerate unbounded mem_rready and mem_rvalid stalls without state loss.
REQ-015 SHALL drive mem_ren=0 in all states except REQ.

Reset
REQ-016 SHALL on rst=1 force IDLE immediately; while rst=1: ld_ready=1, mem_ren=0, mem_raddr=0, gpr_wen=0, gpr_waddr=0, gpr_wdata=0, ld_err=0.
REQ-017 SHALL abandon any in-flight load on reset, with no gpr_wen for it, including when mem_rvalid arrives after reset release.

Configuration
REQ-018 SHALL honour macro YSYX_23060201_LSU_MISALIGN_CHK_EN.
REQ-019 SHALL with the macro defined treat these loads as misaligned at handshake: LH/LHU with addr[0]=1, or LW with addr[1:0]!=0.
REQ-020 SHALL for a misaligned load pulse ld_err=1 for one cycle, never assert mem_ren, never assert gpr_wen, and return to IDLE.
REQ-021 SHALL without the macro tie ld_err=0; LH/LHU ignore addr[0], and LW ignores addr[1:0].

Verification
REQ-022 SHALL cover: LW addr 0x80000004, rd=5, mem_rdata 0xDEADBEEF, zero wait -> mem_raddr 0x80000004; gpr_wen one cycle at handshake+3; gpr_waddr=5; gpr_wdata 0xDEADBEEF.
REQ-023 SHALL cover: LB/LBU addr 0x80000003, rdata 0x80FF1234 -> 0xFFFFFF80 / 0x00000080; mem_raddr 0x80000000.
REQ-024 SHALL cover: LH/LHU addr 0x80000002, rdata 0x80017FFF -> 0xFFFF8001 / 0x00008001.
REQ-025 SHALL cover: mem_rready low 3 cycles, then mem_rvalid 2 cycles after acceptance -> mem_ren and mem_raddr stable, ld_ready=0 throughout, exactly one gpr_wen.
REQ-026 SHALL cover: rd=0 load -> no gpr_wen; rst pulsed during WAIT, then mem_rvalid=1 -> no gpr_wen, and ld_ready=1 after release.
REQ-027 SHALL cover with the macro: LW addr 0x80000002 -> one-cycle ld_err, mem_ren never 1; without the macro the same load -> ld_err=0 and word at 0x80000000 written back.

Source files
------------

// File: rtl/ysyx_23060201_lsu_load.sv
// ysyx_23060201_lsu_load: RV32I load unit, request/wait/write-back FSM with byte/half extraction
// Define YSYX_23060201_LSU_MISALIGN_CHK_EN to trap misaligned LH/LHU/LW with a one-cycle ld_err pulse.
module ysyx_23060201_lsu_load #(
    parameter int MEM_ADDR_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ld_valid,
    output logic                      ld_ready,
    input  logic [MEM_ADDR_WIDTH-1:0] ld_addr,
    input  logic [2:0]                ld_func3,
    input  logic [4:0]                ld_rd,
    output logic                      mem_ren,
    output logic [MEM_ADDR_WIDTH-1:0] mem_raddr,
    input  logic                      mem_rready,
    input  logic                      mem_rvalid,
    input  logic [31:0]               mem_rdata,
    output logic                      gpr_wen,
    output logic [4:0]                gpr_waddr,
    output logic [31:0]               gpr_wdata,
    output logic                      ld_err
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, WB, ERR} state_t;
    state_t state, state_nx;
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [2:0] func3;
    logic [4:0] rd, wb_rd;
    logic [31:0] result, ext;
    logic [7:0] byte_sel;
    logic [15:0] half_sel;
    logic hs, mis;
    assign hs = ld_valid & ld_ready;
`ifdef YSYX_23060201_LSU_MISALIGN_CHK_EN
    // func3[1] covers LW and the reserved codes that behave as LW
    assign mis = (ld_func3[1:0] == 2'b01 && ld_addr[0]) || (ld_func3[1] && ld_addr[1:0] != 2'b00);
    assign ld_err = state == ERR;
`else
    assign mis = 1'b0;
    assign ld_err = 1'b0;
`endif
    always_comb begin
        byte_sel = addr[1] ? (addr[0] ? mem_rdata[31:24] : mem_rdata[23:16])
                           : (addr[0] ? mem_rdata[15:8] : mem_rdata[7:0]);
        half_sel = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ext = func3 == 3'b000 ? {{24{byte_sel[7]}}, byte_sel} :
              func3 == 3'b001 ? {{16{half_sel[15]}}, half_sel} :
              func3 == 3'b100 ? {24'd0, byte_sel} :
              func3 == 3'b101 ? {16'd0, half_sel} : mem_rdata;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = hs ? (mis ? ERR : REQ) : IDLE;
            REQ: state_nx = mem_rready ? WAIT : REQ;
            WAIT: state_nx = mem_rvalid ? WB : WAIT;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            addr <= '0;
            func3 <= '0;
            rd <= '0;
            wb_rd <= '0;
            result <= '0;
        end else begin
            state <= state_nx;
            if (hs) begin
                addr <= ld_addr;
                func3 <= ld_func3;
                rd <= ld_rd;
            end
            if (state == WAIT && mem_rvalid) begin
                result <= ext;
                wb_rd <= rd;
            end
        end
    end
    assign ld_ready = state == IDLE;
    assign mem_ren = state == REQ;
    assign mem_raddr = {addr[MEM_ADDR_WIDTH-1:2], 2'b00};
    assign gpr_wen = state == WB && wb_rd != 5'd0;
    assign gpr_waddr = wb_rd;
    assign gpr_wdata = result;
endmodule
